// File: rtl/product_acc_pkg.sv
// Shared types and default sizing for the product accumulator slice.
// The optional saturating build is selected with the PRODUCT_ACC_SAT_EN macro.
package product_acc_pkg;

    typedef enum logic {ACCUM, HOLD} acc_state_t;

    localparam int PA_WIDTH     = 8;
    localparam int PA_LEN       = 4;
    localparam int PA_ACC_WIDTH = 18;

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// ACC_WIDTH-wide adder that reports carry-out.
// With PRODUCT_ACC_SAT_EN defined the sum clamps to all ones on carry, otherwise it wraps.
module sat_adder
    import product_acc_pkg::*;
#(
    parameter int ACC_WIDTH = PA_ACC_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] a_i,
    input  logic [ACC_WIDTH-1:0] b_i,
    output logic [ACC_WIDTH-1:0] sum_o,
    output logic                 carry_o
);

    logic [ACC_WIDTH:0] rawSum;

    assign rawSum  = {1'b0, a_i} + {1'b0, b_i};
    assign carry_o = rawSum[ACC_WIDTH];

`ifdef PRODUCT_ACC_SAT_EN
    // A clamped accumulator re-carries on any further non-zero add, so it stays clamped.
    assign sum_o = carry_o ? {ACC_WIDTH{1'b1}} : rawSum[ACC_WIDTH-1:0];
`else
    assign sum_o = rawSum[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums groups of LEN products and presents each group sum on a valid/ready port.
// Saturating vs wrapping accumulation is chosen by PRODUCT_ACC_SAT_EN (see sat_adder).
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int WIDTH     = PA_WIDTH,
    parameter int LEN       = PA_LEN,
    parameter int ACC_WIDTH = PA_ACC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_sum,
    output logic                 out_overflow
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    acc_state_t           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 outValid_q, outValid_d;
    logic [ACC_WIDTH-1:0] outSum_q, outSum_d;
    logic                 outOvf_q, outOvf_d;

    logic [ACC_WIDTH-1:0] prodExt;
    logic [ACC_WIDTH-1:0] addSum;
    logic                 addCarry;

    assign prodExt = ACC_WIDTH'(in_product);

    sat_adder #(
        .ACC_WIDTH(ACC_WIDTH)
    ) u_adder (
        .a_i    (acc_q),
        .b_i    (prodExt),
        .sum_o  (addSum),
        .carry_o(addCarry)
    );

    // Ready depends only on state so out_ready never reaches in_ready combinationally.
    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = outValid_q;
    assign out_sum      = outSum_q;
    assign out_overflow = outOvf_q;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        outValid_d = outValid_q;
        outSum_d   = outSum_q;
        outOvf_d   = outOvf_q;
        if (clear) begin
            state_d    = ACCUM;
            acc_d      = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            outValid_d = 1'b0;
            outSum_d   = '0;
            outOvf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        if (cnt_q == LAST_CNT) begin
                            outSum_d   = addSum;
                            outOvf_d   = ovf_q | addCarry;
                            outValid_d = 1'b1;
                            acc_d      = '0;
                            cnt_d      = '0;
                            ovf_d      = 1'b0;
                            state_d    = HOLD;
                        end else begin
                            acc_d = addSum;
                            cnt_d = cnt_q + 1'b1;
                            ovf_d = ovf_q | addCarry;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        outValid_d = 1'b0;
                        state_d    = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            outValid_q <= 1'b0;
            outSum_q   <= '0;
            outOvf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            outValid_q <= outValid_d;
            outSum_q   <= outSum_d;
            outOvf_q   <= outOvf_d;
        end
    end

endmodule
